// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU (master) and the data-memory responder (slave).
// Request and response channels are each a valid/ready handshake.
interface data_mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [2:0]               req_funct3;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data-memory responder with programmable wait states, byte/half/word access and error flagging.
// Optional saturating perf counters (perf_loads/perf_stores/perf_errors) when DMEM_PERF_CNT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; req_ready=1
// ST_WAIT | request latched, down-counting wait states
// ST_RESP | access executed on entry, response held until resp_ready
module data_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]          perf_loads,
    output logic [31:0]          perf_stores,
    output logic [31:0]          perf_errors
`endif
);
    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     write_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH_WORDS];

    logic                     accept, enter_resp, mem_we;
    logic                     op_write, op_err, bad_f3, misaligned, out_of_range;
    logic [2:0]               op_funct3;
    logic [ADDRESS_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0]    op_wdata;
    logic [IDX_W-1:0]         mem_idx;
    logic [DATA_WIDTH-1:0]    rd_word, load_val, st_data;
    logic [7:0]               rd_byte;
    logic [15:0]              rd_half;
    logic [3:0]               st_be;

    assign accept     = bus.req_valid && (state_q == ST_IDLE);
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // With zero wait states the access runs on the accept edge, so operands come straight from the bus.
    assign op_write  = (state_q == ST_IDLE) ? bus.req_write  : write_q;
    assign op_funct3 = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
    assign op_addr   = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
    assign op_wdata  = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;

    assign out_of_range = op_addr[ADDRESS_WIDTH-1:2] >= (ADDRESS_WIDTH-2)'(MEM_DEPTH_WORDS);
    assign misaligned   = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                          ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    assign bad_f3       = op_write ? (op_funct3[2] || (op_funct3[1:0] == 2'b11))
                                   : ((op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11));
    assign op_err       = out_of_range || misaligned || bad_f3;

    assign mem_idx = op_addr[IDX_W+1:2];
    assign rd_word = mem_q[mem_idx];
    assign rd_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
    assign rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = '0;
        case (op_funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        st_be   = 4'b0000;
        st_data = op_wdata;
        case (op_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << op_addr[1:0];
                st_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = op_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{op_wdata[15:0]}};
            end
            2'b10:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (enter_resp) begin
                err_q   <= op_err;
                rdata_q <= (op_err || op_write) ? '0 : load_val;
            end
        end
    end

    // Storage is deliberately outside reset; a reset edge still blocks the commit.
    assign mem_we = enter_resp && op_write && !op_err && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem_q[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] loads_q, stores_q, errors_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            errors_q <= '0;
        end else if (enter_resp) begin
            if (op_err) begin
                if (errors_q != '1) errors_q <= errors_q + 32'd1;
            end else if (op_write) begin
                if (stores_q != '1) stores_q <= stores_q + 32'd1;
            end else begin
                if (loads_q != '1) loads_q <= loads_q + 32'd1;
            end
        end
    end

    assign perf_loads  = loads_q;
    assign perf_stores = stores_q;
    assign perf_errors = errors_q;
`endif
endmodule
